// File: rtl/endian_pkg.sv
// Shared definitions for the byte-stream endian conversion path.
package endian_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 64;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    LAST_BYTE
  } fill_state_e;

  // Lowest n lanes set; callers narrow the result to their own lane count.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/be_word_out_reg.sv
// Output holding register: one packed word with valid/ready, held stable while
// the consumer stalls.
module be_word_out_reg
  import endian_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [BYTES-1:0]  load_keep_i,
  input  logic              load_last_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [BYTES-1:0]  out_keep_o,
  output logic              out_last_o
);

  // A load only happens when the slot is free or draining this cycle, so it
  // always takes priority over the drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_keep_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (load_i) begin
      out_valid_o <= 1'b1;
      out_data_o  <= load_data_i;
      out_keep_o  <= load_keep_i;
      out_last_o  <= load_last_i;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/be_byte_to_le_word_packer.sv
// Packs an MSB-first byte stream into value-ordered words with keep/last.
// Optional BE_BYTE_PACKER_STATS_EN adds saturating word/short-word counters.
module be_byte_to_le_word_packer
  import endian_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_byte_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [BYTES-1:0]  out_keep_o,
  output logic              out_last_o
`ifdef BE_BYTE_PACKER_STATS_EN
  ,
  output logic [15:0]       words_cnt_o,
  output logic [15:0]       short_cnt_o
`endif
);

  localparam int ACC_W = DATA_W - BYTE_W;
  localparam int CNT_W = $clog2(BYTES);

  logic [ACC_W-1:0]  acc_p0;
  logic [CNT_W-1:0]  cnt_p0;
  fill_state_e       state;
  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] next_word;
  logic [BYTES-1:0]  next_keep;

  // The byte count is the control state; the enum only names its regions.
  always_comb begin
    state = FILL;
    if (cnt_p0 == '0)
      state = EMPTY;
    else if (cnt_p0 == CNT_W'(BYTES - 1))
      state = LAST_BYTE;
  end

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign complete   = accept && ((state == LAST_BYTE) || in_last_i);

  // Earlier bytes sit above the new one; the accumulator starts at zero, so
  // short words come out zero-extended.
  assign next_word  = {acc_p0, in_byte_i};
  assign next_keep  = BYTES'(keep_mask(32'(cnt_p0) + 32'd1));

  // ---- stage p0: byte accumulation ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (complete) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      acc_p0 <= next_word[ACC_W-1:0];
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // ---- stage p1: word output register ----
  be_word_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (complete),
    .load_data_i (next_word),
    .load_keep_i (next_keep),
    .load_last_i (in_last_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_keep_o  (out_keep_o),
    .out_last_o  (out_last_o)
  );

`ifdef BE_BYTE_PACKER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic out_hs;
  assign out_hs = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_cnt_o <= '0;
      short_cnt_o <= '0;
    end else if (out_hs) begin
      words_cnt_o <= sat_inc16(words_cnt_o);
      if (out_keep_o != '1)
        short_cnt_o <= sat_inc16(short_cnt_o);
    end
  end
`endif

endmodule
